// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone single-beat initiator.
// State encoding and default widths used by wb_initiator and its watchdog.
package wb_initiator_pkg;

    localparam int DEFAULT_AW      = 32;
    localparam int DEFAULT_DW      = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_initiator_wdog.sv
// Bus-cycle watchdog: counts cycles while enabled, flags the TIMEOUT-th cycle.
// Only built when WB_INITIATOR_TIMEOUT_EN is defined, so the default build carries no counter.
`ifdef WB_INITIATOR_TIMEOUT_EN
module wb_initiator_wdog
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt holds (cycles already spent in BUS), so cnt==TIMEOUT-1 marks the last allowed cycle
    assign expired = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule
`endif

// File: rtl/wb_initiator.sv
// Single-beat Wishbone classic initiator bridging a valid/ready command/response pair.
// Optional ack timeout enabled with the WB_INITIATOR_TIMEOUT_EN macro.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    if ((DW % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("wb_initiator: DW must be a multiple of 8 and TIMEOUT within 1..65535");
    end

    state_t state;
    logic   alive;
    logic   expired;

    // alive keeps cmd_ready low until the first edge after reset releases
    assign cmd_ready_o = alive && (state == IDLE);
    assign wbm_stb_o   = wbm_cyc_o;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic err_q;

    wb_initiator_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (state != BUS),
        .enable  (state == BUS),
        .expired (expired)
    );

    assign rsp_err_o = err_q;
`else
    assign expired   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            alive       <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            alive <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        state     <= BUS;
                        wbm_cyc_o <= 1'b1;
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        wbm_sel_o <= cmd_sel_i;
                    end
                end
                BUS: begin
                    // ack wins over a coinciding timeout
                    if (wbm_ack_i || expired) begin
                        state       <= RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_adr_o   <= '0;
                        wbm_dat_o   <= '0;
                        wbm_sel_o   <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        err_q       <= !wbm_ack_i;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_dat_o   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: write, read, backpressure, back-to-back, reset abort, timeout.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] sdat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_initiator #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_sel_o   (sel),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (sdat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = 4'hF;
    endtask

    task automatic idle_bus();
        chk("idle_cyc", {63'd0, cyc}, 64'd0);
        chk("idle_stb", {63'd0, stb}, 64'd0);
        chk("idle_adr", {32'd0, adr}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        rsp_ready = 0; ack = 0; sdat = 0;
        #2;
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_rvalid", {63'd0, rsp_valid}, 64'd0);
        idle_bus();
        tick(); tick();
        rst = 1'b0;
        chk("ready_before_edge", {63'd0, cmd_ready}, 64'd0);
        tick();
        chk("ready_after_edge", {63'd0, cmd_ready}, 64'd1);

        // write, ack in third BUS cycle
        send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF);
        tick();
        cmd_valid = 0;
        chk("wr_cyc1", {63'd0, cyc}, 64'd1);
        chk("wr_stb1", {63'd0, stb}, 64'd1);
        chk("wr_we", {63'd0, we}, 64'd1);
        chk("wr_adr", {32'd0, adr}, 64'h3000_0004);
        chk("wr_dat", {32'd0, wdat}, 64'hDEAD_BEEF);
        chk("wr_sel", {60'd0, sel}, 64'hF);
        chk("wr_busy", {63'd0, cmd_ready}, 64'd0);
        tick();
        chk("wr_cyc2", {63'd0, cyc}, 64'd1);
        chk("wr_adr2", {32'd0, adr}, 64'h3000_0004);
        tick();
        chk("wr_cyc3", {63'd0, cyc}, 64'd1);
        ack = 1; sdat = 32'hFFFF_FFFF;
        tick();
        ack = 0; sdat = 0;
        idle_bus();
        chk("wr_we_clr", {63'd0, we}, 64'd0);
        chk("wr_rvalid", {63'd0, rsp_valid}, 64'd1);
        chk("wr_rdat", {32'd0, rsp_dat}, 64'd0);
        chk("wr_err", {63'd0, rsp_err}, 64'd0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("wr_rdone", {63'd0, rsp_valid}, 64'd0);
        chk("wr_ready_back", {63'd0, cmd_ready}, 64'd1);

        // stray ack in IDLE
        ack = 1; sdat = 32'h5555_5555;
        tick();
        ack = 0; sdat = 0;
        chk("stray_rvalid", {63'd0, rsp_valid}, 64'd0);
        idle_bus();

        // read, ack in first BUS cycle, then backpressure with a queued command
        send(1'b0, 32'h3000_0010, 32'h0);
        tick();
        cmd_valid = 0;
        chk("rd_cyc", {63'd0, cyc}, 64'd1);
        chk("rd_we", {63'd0, we}, 64'd0);
        chk("rd_adr", {32'd0, adr}, 64'h3000_0010);
        ack = 1; sdat = 32'h1234_5678;
        tick();
        ack = 0; sdat = 0;
        send(1'b1, 32'h3000_0020, 32'hCAFE_F00D);
        chk("rd_cyc_drop", {63'd0, cyc}, 64'd0);
        chk("rd_rdat", {32'd0, rsp_dat}, 64'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rvalid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rdat", {32'd0, rsp_dat}, 64'h1234_5678);
            chk("bp_err", {63'd0, rsp_err}, 64'd0);
            chk("bp_ready", {63'd0, cmd_ready}, 64'd0);
            chk("bp_cyc", {63'd0, cyc}, 64'd0);
        end
        rsp_ready = 1;
        tick();
        chk("b2b_bubble_rvalid", {63'd0, rsp_valid}, 64'd0);
        chk("b2b_bubble_cyc", {63'd0, cyc}, 64'd0);
        chk("b2b_bubble_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 0;
        chk("b2b_cyc", {63'd0, cyc}, 64'd1);
        chk("b2b_adr", {32'd0, adr}, 64'h3000_0020);
        chk("b2b_dat", {32'd0, wdat}, 64'hCAFE_F00D);
        ack = 1;
        tick();
        ack = 0;
        chk("b2b_rvalid", {63'd0, rsp_valid}, 64'd1);
        tick();
        chk("b2b_rdone", {63'd0, rsp_valid}, 64'd0);
        rsp_ready = 0;

        // reset in second BUS cycle of a read
        send(1'b0, 32'h3000_0030, 32'h0);
        tick();
        cmd_valid = 0;
        tick();
        chk("ra_cyc2", {63'd0, cyc}, 64'd1);
        rst = 1;
        #1;
        chk("ra_cyc", {63'd0, cyc}, 64'd0);
        chk("ra_stb", {63'd0, stb}, 64'd0);
        chk("ra_ready", {63'd0, cmd_ready}, 64'd0);
        rst = 0;
        ack = 1; sdat = 32'h7777_7777;
        tick();
        ack = 0; sdat = 0;
        chk("ra_rvalid", {63'd0, rsp_valid}, 64'd0);
        chk("ra_ready_back", {63'd0, cmd_ready}, 64'd1);
        send(1'b0, 32'h3000_0040, 32'h0);
        tick();
        cmd_valid = 0;
        chk("ra_new_cyc", {63'd0, cyc}, 64'd1);
        chk("ra_new_adr", {32'd0, adr}, 64'h3000_0040);
        ack = 1; sdat = 32'hA5A5_5A5A;
        tick();
        ack = 0; sdat = 0;
        chk("ra_new_rdat", {32'd0, rsp_dat}, 64'hA5A5_5A5A);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

`ifdef WB_INITIATOR_TIMEOUT_EN
        // no ack: cyc held exactly 8 cycles, then error response
        send(1'b0, 32'h3000_0050, 32'h0);
        sdat = 32'h9999_9999;
        tick();
        cmd_valid = 0;
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("to_cyc_held", {63'd0, cyc}, 64'd1);
        end
        tick();
        chk("to_cyc_drop", {63'd0, cyc}, 64'd0);
        chk("to_rvalid", {63'd0, rsp_valid}, 64'd1);
        chk("to_err", {63'd0, rsp_err}, 64'd1);
        chk("to_rdat", {32'd0, rsp_dat}, 64'd0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("to_err_clr", {63'd0, rsp_err}, 64'd0);

        // ack on the terminal cycle counts as ack
        send(1'b0, 32'h3000_0060, 32'h0);
        tick();
        cmd_valid = 0;
        for (int k = 2; k <= 8; k++) tick();
        chk("tc_cyc8", {63'd0, cyc}, 64'd1);
        ack = 1; sdat = 32'h0BAD_F00D;
        tick();
        ack = 0; sdat = 0;
        chk("tc_err", {63'd0, rsp_err}, 64'd0);
        chk("tc_rdat", {32'd0, rsp_dat}, 64'h0BAD_F00D);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
`else
        // without the timeout the cycle waits for ack indefinitely
        send(1'b0, 32'h3000_0050, 32'h0);
        tick();
        cmd_valid = 0;
        for (int k = 0; k < 12; k++) tick();
        chk("nt_cyc_held", {63'd0, cyc}, 64'd1);
        chk("nt_rvalid", {63'd0, rsp_valid}, 64'd0);
        ack = 1; sdat = 32'h0BAD_F00D;
        tick();
        ack = 0; sdat = 0;
        chk("nt_err", {63'd0, rsp_err}, 64'd0);
        chk("nt_rdat", {32'd0, rsp_dat}, 64'h0BAD_F00D);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
`endif
        idle_bus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
